// File: rtl/div_if.sv
// Request / write-back bundle between the pipeline and the iterative divider.
interface div_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic [4:0]      reg_waddr_i;
  logic            abort_i;
  logic [XLEN-1:0] result_o;
  logic            ready_o;
  logic            reg_we_o;
  logic [4:0]      reg_waddr_o;
  logic            busy_o;
  logic            hold_req_o;

  // Pipeline side: issues requests, consumes results.
  modport master (
    output start_i, op_i, dividend_i, divisor_i, reg_waddr_i, abort_i,
    input  result_o, ready_o, reg_we_o, reg_waddr_o, busy_o, hold_req_o
  );

  // Divider side.
  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, reg_waddr_i, abort_i,
    output result_o, ready_o, reg_we_o, reg_waddr_o, busy_o, hold_req_o
  );
endinterface

// File: rtl/div_ctrl.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per
// clock, MSB first. Operands are converted to magnitudes before the loop and
// signs are reapplied when the result is registered.
module div_ctrl #(
  parameter int XLEN = 32
) (
  input  logic    clk,
  input  logic    rst,
  div_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE_S  = 2'd0,
    START_S = 2'd1,
    CALC_S  = 2'd2,
    END_S   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;        // dividend, then quotient shift register
  logic [XLEN-1:0] b_q, b_d;        // divisor (magnitude once in CALC)
  logic [XLEN-1:0] rem_q, rem_d;    // partial remainder
  logic [4:0]      cnt_q, cnt_d;
  logic [4:0]      waddr_q, waddr_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      waddr_out_q, waddr_out_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;

  logic            signed_s;
  logic [XLEN:0]   rem_shift_s;
  logic [XLEN:0]   diff_s;
  logic            qbit_s;
  logic [XLEN-1:0] new_rem_s;
  logic [XLEN-1:0] new_quo_s;
  logic [XLEN-1:0] fin_quo_s;
  logic [XLEN-1:0] fin_rem_s;

  // One restoring step plus sign fix-up of the values it produces.
  always_comb begin
    signed_s    = op_q[2] & ~op_q[0];
    rem_shift_s = {rem_q, a_q[XLEN-1]};
    diff_s      = rem_shift_s - {1'b0, b_q};
    qbit_s      = ~diff_s[XLEN];
    if (qbit_s) begin
      new_rem_s = diff_s[XLEN-1:0];
    end else begin
      new_rem_s = rem_shift_s[XLEN-1:0];
    end
    new_quo_s = {a_q[XLEN-2:0], qbit_s};
    if (qneg_q) begin
      fin_quo_s = ~new_quo_s + 32'd1;
    end else begin
      fin_quo_s = new_quo_s;
    end
    if (rneg_q) begin
      fin_rem_s = ~new_rem_s + 32'd1;
    end else begin
      fin_rem_s = new_rem_s;
    end
  end

  // Next-state and datapath control for the IDLE/START/CALC/END sequence.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    waddr_d     = waddr_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    result_d    = result_q;
    waddr_out_d = waddr_out_q;
    ready_d     = 1'b0;
    case (state_q)
      IDLE_S: begin
        if (bus.start_i && !bus.abort_i) begin
          op_d    = bus.op_i;
          a_d     = bus.dividend_i;
          b_d     = bus.divisor_i;
          waddr_d = bus.reg_waddr_i;
          state_d = START_S;
        end else begin
          state_d = IDLE_S;
        end
      end
      START_S: begin
        if (bus.abort_i) begin
          state_d = IDLE_S;
        end else if (b_q == 32'd0) begin
          // Divide by zero skips the loop: all-ones quotient, remainder = dividend.
          if (op_q[1]) begin
            result_d = a_q;
          end else begin
            result_d = 32'hFFFF_FFFF;
          end
          waddr_out_d = waddr_q;
          ready_d     = 1'b1;
          state_d     = END_S;
        end else begin
          qneg_d = signed_s & (a_q[XLEN-1] ^ b_q[XLEN-1]);
          rneg_d = signed_s & a_q[XLEN-1];
          if (signed_s && a_q[XLEN-1]) begin
            a_d = ~a_q + 32'd1;
          end else begin
            a_d = a_q;
          end
          if (signed_s && b_q[XLEN-1]) begin
            b_d = ~b_q + 32'd1;
          end else begin
            b_d = b_q;
          end
          rem_d   = 32'd0;
          cnt_d   = 5'd0;
          state_d = CALC_S;
        end
      end
      CALC_S: begin
        if (bus.abort_i) begin
          state_d = IDLE_S;
        end else begin
          a_d   = new_quo_s;
          rem_d = new_rem_s;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            if (op_q[1]) begin
              result_d = fin_rem_s;
            end else begin
              result_d = fin_quo_s;
            end
            waddr_out_d = waddr_q;
            ready_d     = 1'b1;
            state_d     = END_S;
          end else begin
            state_d = CALC_S;
          end
        end
      end
      END_S: begin
        // Abort and start are both ignored here; write-back always completes.
        state_d = IDLE_S;
      end
      default: begin
        state_d = IDLE_S;
      end
    endcase
    busy_d = (state_d != IDLE_S);
  end

  // State, datapath and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE_S;
      op_q        <= 3'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      rem_q       <= 32'd0;
      cnt_q       <= 5'd0;
      waddr_q     <= 5'd0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      result_q    <= 32'd0;
      waddr_out_q <= 5'd0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      waddr_q     <= waddr_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      result_q    <= result_d;
      waddr_out_q <= waddr_out_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.result_o    = result_q;
  assign bus.ready_o     = ready_q;
  assign bus.reg_we_o    = ready_q;
  assign bus.reg_waddr_o = waddr_out_q;
  assign bus.busy_o      = busy_q;
  assign bus.hold_req_o  = busy_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: hand-computed results, latency, abort and reset.
module tb_div_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  div_if #(.XLEN(32)) bus ();

  div_ctrl #(.XLEN(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request now, expect the write-back after exp_lat edges.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wa,
                        input logic [31:0] exp, input int exp_lat);
    int   lat;
    logic busy_ok;
    bus.start_i     = 1'b1;
    bus.op_i        = op;
    bus.dividend_i  = a;
    bus.divisor_i   = b;
    bus.reg_waddr_i = wa;
    @(posedge clk); #1;
    // Garbage on the inputs while busy must not disturb the operation.
    bus.start_i     = 1'b0;
    bus.dividend_i  = 32'hDEAD_BEEF;
    bus.divisor_i   = 32'd0;
    bus.reg_waddr_i = 5'd31;
    lat     = 0;
    busy_ok = 1'b1;
    while (bus.ready_o !== 1'b1 && lat < 100) begin
      if (bus.busy_o !== 1'b1 || bus.hold_req_o !== 1'b1 || bus.reg_we_o !== 1'b0)
        busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"},    lat,             exp_lat);
    check({tag, "_busy"},   {31'd0, busy_ok}, 32'd1);
    check({tag, "_res"},    bus.result_o,    exp);
    check({tag, "_we"},     {31'd0, bus.reg_we_o}, 32'd1);
    check({tag, "_waddr"},  {27'd0, bus.reg_waddr_o}, {27'd0, wa});
    check({tag, "_endbsy"}, {31'd0, bus.busy_o}, 32'd1);
    @(posedge clk); #1;
    check({tag, "_rdy0"},   {31'd0, bus.ready_o}, 32'd0);
    check({tag, "_idle"},   {31'd0, bus.busy_o},  32'd0);
    check({tag, "_hold"},   bus.result_o,    exp);
  endtask

  initial begin
    int   seen_we;
    total = 0;
    bad   = 0;
    bus.start_i     = 1'b0;
    bus.op_i        = 3'd0;
    bus.dividend_i  = 32'd0;
    bus.divisor_i   = 32'd0;
    bus.reg_waddr_i = 5'd0;
    bus.abort_i     = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("rst_res",   bus.result_o, 32'd0);
    check("rst_waddr", {27'd0, bus.reg_waddr_o}, 32'd0);
    check("rst_rdy",   {31'd0, bus.ready_o}, 32'd0);
    check("rst_we",    {31'd0, bus.reg_we_o}, 32'd0);
    check("rst_busy",  {31'd0, bus.busy_o}, 32'd0);
    check("rst_hold",  {31'd0, bus.hold_req_o}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    // Request presented for the very first edge after release; results chain back-to-back.
    run_op("divu100_7",   3'b101, 32'd100,         32'd7,           5'd5,  32'h0000_000E, 33);
    run_op("div_m7_2",    3'b100, 32'hFFFF_FFF9,   32'd2,           5'd6,  32'hFFFF_FFFD, 33);
    run_op("rem_m7_2",    3'b110, 32'hFFFF_FFF9,   32'd2,           5'd7,  32'hFFFF_FFFF, 33);
    run_op("remu_m7_2",   3'b111, 32'hFFFF_FFF9,   32'd2,           5'd8,  32'h0000_0001, 33);
    run_op("div5_0",      3'b100, 32'd5,           32'd0,           5'd9,  32'hFFFF_FFFF, 1);
    run_op("remu5_0",     3'b111, 32'd5,           32'd0,           5'd10, 32'h0000_0005, 1);
    run_op("div_ovf",     3'b100, 32'h8000_0000,   32'hFFFF_FFFF,   5'd11, 32'h8000_0000, 33);
    run_op("rem_ovf",     3'b110, 32'h8000_0000,   32'hFFFF_FFFF,   5'd12, 32'h0000_0000, 33);
    run_op("div_100_m7",  3'b100, 32'd100,         32'hFFFF_FFF9,   5'd13, 32'hFFFF_FFF2, 33);

    // Abort in the 10th CALC cycle; a start during CALC is ignored.
    bus.start_i = 1'b1; bus.op_i = 3'b101; bus.dividend_i = 32'hFFFF_FFFF;
    bus.divisor_i = 32'd3; bus.reg_waddr_i = 5'd20;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (2) @(posedge clk); #1;
    bus.start_i = 1'b1; bus.op_i = 3'b101; bus.dividend_i = 32'd1;
    bus.divisor_i = 32'd1; bus.reg_waddr_i = 5'd3;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    check("abt_busy3", {31'd0, bus.busy_o}, 32'd1);
    repeat (7) @(posedge clk); #1;
    check("abt_busy10", {31'd0, bus.busy_o}, 32'd1);
    bus.abort_i = 1'b1;
    @(posedge clk); #1;
    bus.abort_i = 1'b0;
    check("abt_idle", {31'd0, bus.busy_o}, 32'd0);
    check("abt_rdy",  {31'd0, bus.ready_o}, 32'd0);
    seen_we = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.reg_we_o !== 1'b0 || bus.busy_o !== 1'b0) seen_we++;
    end
    check("abt_no_we", seen_we, 32'd0);
    check("abt_res",   bus.result_o, 32'hFFFF_FFF2);
    check("abt_waddr", {27'd0, bus.reg_waddr_o}, 32'd13);

    // Abort together with start in IDLE drops the request.
    bus.start_i = 1'b1; bus.abort_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.abort_i = 1'b0;
    check("idle_abt", {31'd0, bus.busy_o}, 32'd0);
    run_op("divu9_3", 3'b101, 32'd9, 32'd3, 5'd14, 32'h0000_0003, 33);

    // Asynchronous reset in the middle of CALC.
    bus.start_i = 1'b1; bus.op_i = 3'b101; bus.dividend_i = 32'd100;
    bus.divisor_i = 32'd7; bus.reg_waddr_i = 5'd21;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (5) @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mrst_res",   bus.result_o, 32'd0);
    check("mrst_waddr", {27'd0, bus.reg_waddr_o}, 32'd0);
    check("mrst_busy",  {31'd0, bus.busy_o}, 32'd0);
    check("mrst_hold",  {31'd0, bus.hold_req_o}, 32'd0);
    check("mrst_rdy",   {31'd0, bus.ready_o}, 32'd0);
    check("mrst_we",    {31'd0, bus.reg_we_o}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    seen_we = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.reg_we_o !== 1'b0 || bus.busy_o !== 1'b0) seen_we++;
    end
    check("mrst_no_we", seen_we, 32'd0);
    run_op("divu_max_1", 3'b101, 32'hFFFF_FFFF, 32'd1, 5'd15, 32'hFFFF_FFFF, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; one clock, reset asynchronous and active-low (rst=0 resets immediately, release synchronous to clk).
REQ-004 start_i  input  1  request to begin a divide/remainder operation.
REQ-005 op_i  input  3  funct3 of the request: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 dividend_i  input  32  rs1 value.
REQ-007 divisor_i  input  32  rs2 value.
REQ-008 reg_waddr_i  input  5  destination register of the request.
REQ-009 abort_i  input  1  cancel the in-flight operation (interrupt/flush).
REQ-010 result_o  output  32  quotient or remainder.
REQ-011 ready_o  output  1  result_o valid, one-cycle pulse.
REQ-012 reg_we_o  output  1  write-back enable to the register file, one-cycle pulse.
REQ-013 reg_waddr_o  output  5  write-back register address.
REQ-014 busy_o  output  1  operation in flight.
REQ-015 hold_req_o  output  1  pipeline hold request to the pipeline controller.

Function
REQ-016 FSM states IDLE, START, CALC, END; state SHALL be registered.
REQ-017 IDLE: start_i=1 and abort_i=0 at edge N -> START; op_i, dividend_i, divisor_i, reg_waddr_i latched at edge N.
REQ-018 start_i, operand and address inputs SHALL be ignored in any state other than IDLE.
REQ-019 START: divisor==0 -> END at edge N+1; otherwise latch absolute values (signed ops) or raw values (unsigned ops), clear 5-bit iteration counter -> CALC.
REQ-020 CALC: restoring shift-subtract, one quotient bit per edge, MSB first; 32 iterations on edges N+2..N+33; counter wraps 31->0 exactly when the state moves to END at N+33.
REQ-021 END: ready_o=1, reg_we_o=1 and result_o valid for exactly one cycle; the next edge -> IDLE.
REQ-022 Latency: ready_o high in the cycle following edge N+33 (normal) or edge N+1 (divide by zero).
REQ-023 Signed ops: quotient truncates toward zero, negated when operand signs differ; remainder takes the sign of the dividend.
REQ-024 Divisor 0: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = dividend.
REQ-025 Overflow: DIV 0x80000000 / 0xFFFFFFFF SHALL give 0x80000000; REM gives 0; no special state.
REQ-026 busy_o = hold_req_o = (state != IDLE).
REQ-027 abort_i=1 in START or CALC -> IDLE next edge, with no ready_o or reg_we_o pulse; abort_i in IDLE has no effect, and a simultaneous start_i is dropped.
REQ-028 abort_i in END has no effect: the write-back completes.
REQ-029 result_o and reg_waddr_o SHALL be registered and hold their last values after END until the next END.
REQ-030 Back-to-back: start_i in the IDLE cycle directly after END SHALL be accepted, with no dead cycle required.

Reset
REQ-031 rst=0: state IDLE, counter 0, result_o 0, reg_waddr_o 0, ready_o 0, reg_we_o 0, busy_o 0, hold_req_o 0, all asynchronously.
REQ-032 Reset during START/CALC/END discards the operation and produces no write-back after release.
REQ-033 First start_i is accepted on the first rising edge with rst=1.

Verification
REQ-034 DIVU 100/7, waddr 5 at edge N -> ready_o and reg_we_o high only after edge N+33, result_o 0x0000000E, reg_waddr_o 5; busy_o and hold_req_o high for edges N..N+33.
REQ-035 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; REMU 0xFFFFFFF9/2 -> 0x00000001.
REQ-036 DIV 5/0 -> 0xFFFFFFFF with ready after edge N+1; REMU 5/0 -> 0x00000005.
REQ-037 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0x00000000.
REQ-038 abort_i at the 10th CALC cycle -> IDLE next edge, no reg_we_o pulse; start_i during CALC is ignored; a new DIVU 9/3 issued afterwards -> 0x00000003.
REQ-039 rst=0 mid-CALC -> all outputs 0 without a clock edge; no write-back after release.
